// File: rtl/instr_fetch.sv
// Multicycle instruction fetch unit: latches a PC, performs one memory read over a
// req/ready handshake, and strobes the instruction register; reports misaligned PCs and timeouts.
module instr_fetch #(
    parameter int AddrSize      = 64,
    parameter int InstrSize     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [AddrSize-1:0]  pc_i,
    output logic                 mem_req_o,
    output logic [AddrSize-1:0]  mem_addr_o,
    input  logic                 mem_ready_i,
    input  logic [InstrSize-1:0] mem_rdata_i,
    output logic [InstrSize-1:0] instr_o,
    output logic                 ir_load_o,
    output logic                 busy_o,
    output logic                 fault_o,
    output logic [1:0]           cause_o
);

    localparam int CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    localparam logic [1:0] CauseNone     = 2'b00;
    localparam logic [1:0] CauseMisalign = 2'b01;
    localparam logic [1:0] CauseTimeout  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [CntW-1:0]       cnt_reg, cnt_next;
    logic [AddrSize-1:0]   addr_reg, addr_next;
    logic [InstrSize-1:0]  instr_reg, instr_next;
    logic [1:0]            cause_reg, cause_next;
    logic                  mem_req_reg, ir_load_reg, busy_reg, fault_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        instr_next = instr_reg;
        cause_next = cause_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    if (pc_i[1:0] != 2'b00) begin
                        state_next = FAULT;
                        cause_next = CauseMisalign;
                    end else begin
                        state_next = REQ;
                        addr_next  = pc_i;
                        cnt_next   = '0;
                        cause_next = CauseNone;
                    end
                end
            end
            REQ: begin
                // A response in the final allowed cycle still completes the fetch.
                if (mem_ready_i) begin
                    instr_next = mem_rdata_i;
                    state_next = DONE;
                end else if (cnt_reg == CntLast) begin
                    state_next = FAULT;
                    cause_next = CauseTimeout;
                end else begin
                    cnt_next = cnt_reg + CntW'(1);
                end
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change only on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            instr_reg   <= '0;
            cause_reg   <= CauseNone;
            mem_req_reg <= 1'b0;
            ir_load_reg <= 1'b0;
            busy_reg    <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            instr_reg   <= instr_next;
            cause_reg   <= cause_next;
            mem_req_reg <= (state_next == REQ);
            ir_load_reg <= (state_next == DONE);
            busy_reg    <= (state_next != IDLE);
            fault_reg   <= (state_next == FAULT);
        end
    end

    assign mem_req_o  = mem_req_reg;
    assign mem_addr_o = addr_reg;
    assign instr_o    = instr_reg;
    assign ir_load_o  = ir_load_reg;
    assign busy_o     = busy_reg;
    assign fault_o    = fault_reg;
    assign cause_o    = cause_reg;

endmodule
